// File: rtl/spi_target_regs.sv
// ---------------------------------------------------------------------------
// spi_target_regs
//
// SPI mode-0 target with a four-entry register file. SCLK, SSn and MOSI are
// oversampled on clk_50; nothing in this block is clocked by SCLK.
//
// Frame: 16 bits, MSB first.
//   byte 0 = command: bit7 R/nW (1 = read), bits[1:0] address
//   byte 1 = data (write) / register value returned on MISO (read and write)
//
// Address map: 0 ID_VALUE (RO), 1 status_in snapshot (RO),
//              2 ctrl0_q (RW), 3 ctrl1_q (RW)
//
// Ports:
//   clk_50        system clock
//   fpga_reset_n  asynchronous active-low reset
//   spi_sclk      SPI clock (CPOL=0)
//   spi_ssn       target select, active-low
//   spi_mosi      master-out data
//   spi_miso      target-out data
//   spi_miso_oe   MISO output enable, high while selected
//   status_in     status byte, sampled when an address-1 read is loaded
//   ctrl0_q       control register, address 2
//   ctrl1_q       control register, address 3
//   wr_strobe     one-cycle pulse on a control register write
//   wr_addr       address of the last control register write
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not selected, waiting for SSn low
// CMD   | shifting in the command byte
// DATA  | shifting the data byte in and the addressed value out
// DONE  | frame complete, further SCLK edges ignored until SSn high
// ---------------------------------------------------------------------------
module spi_target_regs #(
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter logic [7:0] CTRL_RESET = 8'h00
) (
    input  logic       clk_50,
    input  logic       fpga_reset_n,
    input  logic       spi_sclk,
    input  logic       spi_ssn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl0_q,
    output logic [7:0] ctrl1_q,
    output logic       wr_strobe,
    output logic [1:0] wr_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Synchronizer chains. SSn stages reset low so that a target held
    // selected through reset never sees a fresh SSn fall; the armed flag
    // then demands an SSn-high period before the first frame is accepted.
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic ssn_s1_q,  ssn_s2_q,  ssn_s3_q;
    logic mosi_s1_q, mosi_s2_q;
    logic armed_q,   armed_d;

    state_t     state_q,    state_d;
    logic [4:0] bit_cnt_q,  bit_cnt_d;
    logic [6:0] rx_sr_q,    rx_sr_d;
    logic [7:0] tx_sr_q,    tx_sr_d;
    logic       cmd_rd_q,   cmd_rd_d;
    logic [1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0] ctrl0_d,    ctrl1_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [1:0] wr_addr_q,  wr_addr_d;

    logic       sclk_rise, sclk_fall, ssn_rise;
    logic [7:0] rx_byte;
    logic [7:0] rd_value;

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign ssn_rise  = ssn_s2_q & ~ssn_s3_q;

    // Completed byte including the bit arriving on this rise.
    assign rx_byte = {rx_sr_q, mosi_s2_q};

    always_comb begin
        rd_value = ID_VALUE;
        case (cmd_addr_q)
            2'd0:    rd_value = ID_VALUE;
            2'd1:    rd_value = status_in;
            2'd2:    rd_value = ctrl0_q;
            default: rd_value = ctrl1_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_addr_d  = cmd_addr_q;
        ctrl0_d     = ctrl0_q;
        ctrl1_d     = ctrl1_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        armed_d     = armed_q | ssn_s2_q;

        if (ssn_rise) begin
            // Deselect aborts whatever frame is in flight.
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = 5'd0;
                    rx_sr_d   = 7'd0;
                    tx_sr_d   = 8'd0;
                    if (armed_q && !ssn_s2_q) begin
                        state_d = CMD;
                    end
                end

                CMD: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            cmd_rd_d   = rx_byte[7];
                            cmd_addr_d = rx_byte[1:0];
                            state_d    = DATA;
                        end
                    end
                end

                DATA: begin
                    if (sclk_fall) begin
                        // First fall after the command byte loads the
                        // addressed value; later falls shift it out.
                        if (bit_cnt_q == 5'd8) begin
                            tx_sr_d = rd_value;
                        end else begin
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            state_d = DONE;
                            if (!cmd_rd_q && cmd_addr_q[1]) begin
                                if (cmd_addr_q[0]) begin
                                    ctrl1_d = rx_byte;
                                end else begin
                                    ctrl0_d = rx_byte;
                                end
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = cmd_addr_q;
                            end
                        end
                    end
                end

                default: begin
                    // DONE: hold until SSn rises.
                end
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_s3_q   <= 1'b0;
            ssn_s1_q    <= 1'b0;
            ssn_s2_q    <= 1'b0;
            ssn_s3_q    <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 5'd0;
            rx_sr_q     <= 7'd0;
            tx_sr_q     <= 8'd0;
            cmd_rd_q    <= 1'b0;
            cmd_addr_q  <= 2'd0;
            ctrl0_q     <= CTRL_RESET;
            ctrl1_q     <= CTRL_RESET;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 2'd0;
        end else begin
            sclk_s1_q   <= spi_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_s3_q   <= sclk_s2_q;
            ssn_s1_q    <= spi_ssn;
            ssn_s2_q    <= ssn_s1_q;
            ssn_s3_q    <= ssn_s2_q;
            mosi_s1_q   <= spi_mosi;
            mosi_s2_q   <= mosi_s1_q;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_addr_q  <= cmd_addr_d;
            ctrl0_q     <= ctrl0_d;
            ctrl1_q     <= ctrl1_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign spi_miso    = (state_q == DATA) & tx_sr_q[7];
    assign spi_miso_oe = armed_q & ~ssn_s2_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;

endmodule

// File: doc/spi_target_regs.md
# spi_target_regs

SPI mode-0 target (responder) with a small register file, the far end of the SPI master link in the Nios II subsystem. It sits in the FPGA fabric on the `clk_50` domain. It lets an external SPI master (or the on-chip `spi_0` master in loopback) read an ID byte and a status snapshot, and write two control bytes. Bit timing is recovered by oversampling SCLK with `clk_50`; no logic is clocked by SCLK.

## Interface
Parameters:
- `ID_VALUE`, 8'hA5: constant returned at address 0.
- `CTRL_RESET`, 8'h00: reset value of both control registers.

Ports:
- `clk_50`  in  1  system clock (50 MHz).
- `fpga_reset_n`  in  1  reset, asynchronous assert, active-low.
- `spi_sclk`  in  1  SPI clock from master, idle low (CPOL=0).
- `spi_ssn`  in  1  target select, active-low.
- `spi_mosi`  in  1  master-out data, MSB first.
- `spi_miso`  out  1  target-out data, MSB first.
- `spi_miso_oe`  out  1  MISO output enable; high while selected.
- `status_in`  in  8  status byte; snapshotted for address 1 reads.
- `ctrl0_q`  out  8  control register at address 2.
- `ctrl1_q`  out  8  control register at address 3.
- `wr_strobe`  out  1  one-cycle pulse when a control register is written.
- `wr_addr`  out  2  address of the last write; valid with `wr_strobe`.

## Operation
- Input sync: `spi_sclk`, `spi_ssn` and `spi_mosi` each pass through a 2-FF synchronizer plus a third stage for edge detection.
  - rise = stage2 & ~stage3.
  - fall = ~stage2 & stage3.
  - MOSI is taken from its stage2 on rise.
- Frame format: 16 bits, MSB first.
  - Byte 0 is the command: bit7 R/nW (1 = read), bits[1:0] address, bits[6:2] ignored.
  - Byte 1 is the data.
- Address map: 0 = `ID_VALUE` (RO), 1 = `status_in` snapshot (RO), 2 = `ctrl0_q` (RW), 3 = `ctrl1_q` (RW).
- States:
  - IDLE: synced SSn high. Go to CMD on synced SSn low; bit_cnt clears to 0.
  - CMD: shift MOSI into rx_sr on each rise and increment bit_cnt. After the 8th rise, latch the command and go to DATA.
  - DATA: on the fall where bit_cnt==8, load tx_sr with the addressed value. Address 1 samples `status_in` in that cycle. On later falls, shift tx_sr left with 0 fill. On each rise, shift rx_sr. After the 16th rise, go to DONE.
    - For a write to address 2/3: update the control register and pulse `wr_strobe` in the same cycle, with `wr_addr` set.
    - Writes to address 0/1 are ignored: no register change, no strobe.
  - DONE: ignore further SCLK edges; MISO = 0. Leave only when SSn goes high.
- Synced SSn rising in any state returns to IDLE on the next cycle, clears bit_cnt, and aborts the frame. An incomplete write never updates a register.
- `spi_miso` = tx_sr[7] in DATA, 0 otherwise. Write frames also return the current register value on MISO during byte 1.
- `spi_miso_oe` = synced SSn low.

## Timing
- Reset (async, fpga_reset_n low):
  - state IDLE, all shift registers and bit_cnt 0.
  - `spi_miso`=0, `spi_miso_oe`=0, `wr_strobe`=0, `wr_addr`=0.
  - `ctrl0_q`=`ctrl1_q`=`CTRL_RESET`.
  - Reset mid-frame discards the frame. After release, the target waits for SSn high then low before accepting a new frame.
- Edge detect latency: 2-3 `clk_50` cycles from pin to rise/fall pulse.
- Write: `ctrl*_q` and `wr_strobe` update 1 cycle after the 16th rise pulse, i.e. 3-4 cycles after the pin edge. `wr_strobe` is high for exactly 1 cycle.
- MISO changes 3-4 cycles after the SCLK falling pin edge.
- Supported SCLK: at most `clk_50`/8 (6.25 MHz), with high and low phases each at least 4 `clk_50` cycles.
- SSn setup/hold: SSn must be low at least 4 cycles before the first SCLK rise, and stay low at least 4 cycles after the last fall.

## Test plan
- Reset: with `CTRL_RESET`=8'h3C, assert reset mid-frame -> `ctrl0_q`=`ctrl1_q`=8'h3C, `spi_miso_oe`=0, `wr_strobe`=0.
- Read ID: frame 8'h80,8'h00 at SCLK = clk/8 -> MISO byte 1 = 8'hA5, no `wr_strobe`.
- Write then read: frame 8'h02,8'h5A -> `ctrl0_q`=8'h5A, one `wr_strobe` with `wr_addr`=2. Then frame 8'h82,8'h00 -> MISO 8'h5A.
- Status snapshot: `status_in`=8'hC3 at the load point, changed to 8'h00 mid-byte, with frame 8'h81 -> MISO reads 8'hC3.
- Abort: frame 8'h03 plus 5 data bits, then SSn high -> `ctrl1_q` unchanged, no strobe. The next full frame 8'h83 reads the old value.
- Overlong frame: 24 bits 8'h03,8'hF0,8'hFF -> `ctrl1_q`=8'hF0, exactly one strobe, MISO=0 during the 3rd byte. Write to address 0 (8'h00,8'h11) -> no strobe, ID still reads 8'hA5.
